// File: rtl/video_stream_arbiter.sv
// rtl/video_stream_arbiter.sv - frame-granular round-robin arbiter sharing one video filter between two AXI4-Stream sources
module video_stream_arbiter #(
    parameter int FRAME_LINES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] s0_axis_video_tdata,
    input  logic        s0_axis_video_tvalid,
    output logic        s0_axis_video_tready,
    input  logic        s0_axis_video_tuser,
    input  logic        s0_axis_video_tlast,
    input  logic [23:0] s1_axis_video_tdata,
    input  logic        s1_axis_video_tvalid,
    output logic        s1_axis_video_tready,
    input  logic        s1_axis_video_tuser,
    input  logic        s1_axis_video_tlast,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tdest,
    input  logic        arb_hold,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err_early_sof
);

    typedef enum logic {ARB_IDLE, ARB_FRAME} arb_state_t;

    localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);

    arb_state_t  state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        err_q, err_d;

    logic [23:0] src_tdata;
    logic        src_tvalid, src_tuser, src_tlast;
    logic        req0, req1, early_sof;

    always_comb begin
        src_tdata  = sel_q ? s1_axis_video_tdata  : s0_axis_video_tdata;
        src_tvalid = sel_q ? s1_axis_video_tvalid : s0_axis_video_tvalid;
        src_tuser  = sel_q ? s1_axis_video_tuser  : s0_axis_video_tuser;
        src_tlast  = sel_q ? s1_axis_video_tlast  : s0_axis_video_tlast;
        req0       = s0_axis_video_tvalid && s0_axis_video_tuser;
        req1       = s1_axis_video_tvalid && s1_axis_video_tuser;
        early_sof  = src_tvalid && src_tuser && (line_cnt_q != 16'd0);

        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        line_cnt_d   = line_cnt_q;
        err_d        = 1'b0;

        m_axis_video_tdata   = src_tdata;
        m_axis_video_tuser   = src_tuser;
        m_axis_video_tlast   = src_tlast;
        m_axis_video_tvalid  = 1'b0;
        s0_axis_video_tready = 1'b0;
        s1_axis_video_tready = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Drain non-SOF beats so a source realigns to its next frame start.
                s0_axis_video_tready = !s0_axis_video_tuser;
                s1_axis_video_tready = !s1_axis_video_tuser;
                if (!arb_hold && (req0 || req1)) begin
                    state_d = ARB_FRAME;
                    sel_d   = (req0 && req1) ? !last_grant_q : req1;
                end
            end
            ARB_FRAME: begin
                if (early_sof) begin
                    // Abort without consuming the SOF so it can win the next arbitration.
                    state_d      = ARB_IDLE;
                    line_cnt_d   = 16'd0;
                    last_grant_d = sel_q;
                    err_d        = 1'b1;
                end else begin
                    m_axis_video_tvalid = src_tvalid;
                    if (sel_q) s1_axis_video_tready = m_axis_video_tready;
                    else       s0_axis_video_tready = m_axis_video_tready;
                    if (src_tvalid && m_axis_video_tready && src_tlast) begin
                        if (line_cnt_q == LAST_LINE) begin
                            state_d      = ARB_IDLE;
                            line_cnt_d   = 16'd0;
                            last_grant_d = sel_q;
                        end else begin
                            line_cnt_d = line_cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            line_cnt_q   <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            line_cnt_q   <= line_cnt_d;
            err_q        <= err_d;
        end
    end

    assign busy              = (state_q == ARB_FRAME);
    assign grant             = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign m_axis_video_tdest = sel_q;
    assign err_early_sof     = err_q;

endmodule
